// File: rtl/cc_seq.sv
// Sequential compute core: loads a frame of N signed samples, optionally sorts it and
// removes its mean, then evaluates one of two equations on elements 0..3.
module cc_seq #(
    parameter  int N     = 4,
    parameter  int W     = 4,
    localparam int OUT_W = 2 * W + 4,
    localparam int LGN   = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [W-1:0]     in_data,
    input  logic        [3:0]       opt,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_n
);

    localparam int BW = $clog2(OUT_W);

    typedef enum logic [2:0] {LOAD, MEAN, CALC, DIV, DONE} state_t;

    state_t                  state;
    logic [LGN-1:0]          count;
    logic [3:0]              opt_q;
    logic signed [W-1:0]     arr [N];
    logic signed [W-1:0]     srt [N];
    logic signed [W:0]       d   [4];
    logic [OUT_W-1:0]        dvd;
    logic [1:0]              rem;
    logic                    neg;
    logic [BW-1:0]           bits;

    logic [N-1:0]            le;
    logic [N-1:0]            le_prev;
    logic signed [W-1:0]     srt_prev [N];
    logic signed [W-1:0]     ins [N];
    logic signed [W-1:0]     x   [N];
    logic signed [W+LGN-1:0] sum;
    logic [W+LGN-1:0]        mag;
    logic [W:0]              mean_mag;
    logic signed [W:0]       mean;
    logic signed [W:0]       dn  [4];
    logic signed [OUT_W-1:0] e   [4];
    logic signed [OUT_W-1:0] r_eq0;
    logic signed [OUT_W-1:0] p_eq1;
    logic [OUT_W-1:0]        p_abs;
    logic [2:0]              trial;

    // Sorted insertion: entries <= the new sample stay, the slot after them takes it,
    // and the remaining valid entries shift up by one.
    always_comb begin
        le_prev[0]  = 1'b1;
        srt_prev[0] = in_data;
        for (int i = 0; i < N; i++) begin
            le[i] = (i < int'(count)) && (srt[i] <= in_data);
        end
        for (int i = 1; i < N; i++) begin
            le_prev[i]  = le[i-1];
            srt_prev[i] = srt[i-1];
        end
        for (int i = 0; i < N; i++) begin
            if (i > int'(count) || le[i]) ins[i] = srt[i];
            else if (le_prev[i])          ins[i] = in_data;
            else                          ins[i] = srt_prev[i];
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            if (!opt_q[0])     x[i] = arr[i];
            else if (opt_q[1]) x[i] = srt[i];
            else               x[i] = srt[N-1-i];
            sum = sum + (W+LGN)'(x[i]);
        end
        // Magnitude is taken unsigned so the most negative sum still divides correctly.
        mag      = sum[W+LGN-1] ? -sum : sum;
        mean_mag = (W+1)'(mag >> LGN);
        mean     = '0;
        if (opt_q[2]) mean = sum[W+LGN-1] ? -$signed(mean_mag) : $signed(mean_mag);
        for (int i = 0; i < 4; i++) begin
            dn[i] = (W+1)'(x[i]) - mean;
            e[i]  = OUT_W'(d[i]);
        end
        r_eq0 = (e[0] <<< 1) * e[1] + e[3];
        p_eq1 = ((e[2] <<< 2) + e[3]) * e[1];
        p_abs = p_eq1[OUT_W-1] ? -p_eq1 : p_eq1;
        trial = {rem, dvd[OUT_W-1]};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values of all others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            count     <= '0;
            opt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_n     <= '0;
            dvd       <= '0;
            rem       <= '0;
            neg       <= 1'b0;
            bits      <= '0;
            // NOTE: sample storage is small register state, so clearing it on reset is
            // cheap and keeps an aborted frame from leaking into the next one.
            for (int i = 0; i < N; i++) begin
                arr[i] <= '0;
                srt[i] <= '0;
            end
            for (int i = 0; i < 4; i++) d[i] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_n     <= '0;
                    if (in_valid && in_ready) begin
                        arr[count] <= in_data;
                        for (int i = 0; i < N; i++) srt[i] <= ins[i];
                        if (count == '0) opt_q <= opt;
                        if (count == LGN'(N - 1)) begin
                            count    <= '0;
                            in_ready <= 1'b0;
                            state    <= MEAN;
                        end else begin
                            count <= count + LGN'(1);
                        end
                    end
                end
                MEAN: begin
                    for (int i = 0; i < 4; i++) d[i] <= dn[i];
                    state <= CALC;
                end
                CALC: begin
                    if (opt_q[3]) begin
                        dvd   <= r_eq0;
                        neg   <= 1'b0;
                        state <= DONE;
                    end else begin
                        dvd   <= p_abs;
                        neg   <= p_eq1[OUT_W-1];
                        rem   <= '0;
                        bits  <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    // Quotient bits shift into dvd from the right as dividend bits leave.
                    if (trial >= 3'd3) begin
                        rem <= 2'(trial - 3'd3);
                        dvd <= {dvd[OUT_W-2:0], 1'b1};
                    end else begin
                        rem <= trial[1:0];
                        dvd <= {dvd[OUT_W-2:0], 1'b0};
                    end
                    bits <= bits + BW'(1);
                    if (bits == BW'(OUT_W - 1)) state <= DONE;
                end
                DONE: begin
                    out_valid <= 1'b1;
                    out_n     <= neg ? -dvd : dvd;
                    in_ready  <= 1'b0;
                    state     <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_seq.sv
// Directed bench for cc_seq (N=4, W=4): hand-computed results, latency, strobe shape,
// handshake gaps and reset aborts.
module tb_cc_seq;

    localparam int N     = 4;
    localparam int W     = 4;
    localparam int OUT_W = 12;
    localparam int LAT0  = 3;
    localparam int LAT1  = 3 + OUT_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic signed [W-1:0]     in_data;
    logic [3:0]              opt;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [OUT_W-1:0] out_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cc_seq #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .opt      (opt),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_n    (out_n)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_sample(input int s, input logic [3:0] o);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) check("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = W'(s);
        opt      = o;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input int s0, input int s1, input int s2, input int s3,
                              input logic [3:0] o, input bit gaps, input bit noise,
                              input bit hold);
        int s [4];
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            if (gaps && i > 0) repeat (i) @(negedge clk);
            send_sample(s[i], (i == 0 || !noise) ? o : ~o);
        end
        if (hold) in_valid = 1'b1;
    endtask

    task automatic wait_result(input string tag, input int exp_val, input int exp_lat);
        int k = -1;
        int nz = 0;
        int busy = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out_valid) begin
                k = c;
                break;
            end
            if (out_n !== '0) nz++;
            if (in_ready !== 1'b0) busy++;
        end
        check({tag, "_latency"}, k, exp_lat);
        check({tag, "_idle_out_zero"}, nz, 0);
        check({tag, "_busy_not_ready"}, busy, 0);
        in_valid = 1'b0;
        if (k >= 0) begin
            check({tag, "_value"}, out_n, exp_val);
            check({tag, "_done_not_ready"}, in_ready, 0);
            @(negedge clk);
            check({tag, "_strobe_one_cycle"}, out_valid, 0);
            check({tag, "_out_cleared"}, out_n, 0);
            check({tag, "_ready_back"}, in_ready, 1);
        end
    endtask

    initial begin
        int pulses;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        opt      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_n", out_n, 0);
        rst = 1'b0;

        send_frame(1, 2, 3, 4, 4'b0000, 0, 0, 0);
        wait_result("eq1_basic", 10, LAT1);
        send_frame(1, 2, 3, 4, 4'b1000, 0, 0, 0);
        wait_result("eq0_basic", 8, LAT0);
        send_frame(3, -2, 7, 0, 4'b1001, 0, 0, 0);
        wait_result("sort_desc", 40, LAT0);
        send_frame(3, -2, 7, 0, 4'b1011, 0, 0, 0);
        wait_result("sort_asc", 7, LAT0);
        send_frame(-8, -8, -8, -7, 4'b0100, 0, 0, 0);
        wait_result("mean_neg_trunc", 1, LAT1);
        send_frame(0, -1, 1, 0, 4'b0000, 0, 0, 0);
        wait_result("div_neg", -1, LAT1);
        send_frame(-8, -8, 5, -8, 4'b1000, 0, 0, 0);
        wait_result("eq0_extreme", 120, LAT0);
        send_frame(1, 2, 3, 4, 4'b1100, 0, 0, 0);
        wait_result("mean_pos_eq0", 2, LAT0);
        send_frame(-8, -8, -8, -8, 4'b1100, 0, 0, 0);
        wait_result("mean_min_sum", 0, LAT0);
        send_frame(-8, 7, -8, -8, 4'b0000, 0, 0, 0);
        wait_result("div_big_neg", -93, LAT1);
        send_frame(1, 2, 3, 4, 4'b0000, 1, 0, 0);
        wait_result("valid_gaps", 10, LAT1);
        send_frame(1, 2, 3, 4, 4'b1000, 0, 1, 0);
        wait_result("opt_ignored", 8, LAT0);
        send_frame(0, -1, 1, 0, 4'b0000, 0, 0, 1);
        wait_result("valid_held_div", -1, LAT1);

        send_sample(5, 4'b0000);
        send_sample(6, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midframe_rst_ready", in_ready, 1);
        send_frame(1, 2, 3, 4, 4'b1000, 0, 0, 0);
        wait_result("after_midframe_rst", 8, LAT0);

        send_frame(1, 2, 3, 4, 4'b0000, 0, 0, 0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("div_rst_ready", in_ready, 1);
        check("div_rst_out_valid", out_valid, 0);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("div_rst_no_strobe", pulses, 0);
        send_frame(-8, 7, -8, -8, 4'b0000, 0, 0, 0);
        wait_result("after_div_rst", -93, LAT1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
